spi_slave_core: RTL
===================

// Module: spi_slave_core
// PURPOSE
//  SPI responder (slave) for the serial side of the spi_if slave_port, mode 0 (CPOL=0, CPHA=0), MSB first.
//  Oversamples async SCLK/MOSI/SS_N in the system clock domain, deserialises MOSI and serialises MISO.
//  Multi-word frames supported: one word per DATA_W SCLK cycles while SS_N stays low.
//  Sits between the SPI pins and the slave-side parallel data (slave_data_in / slave_data_out).
// PARAMETERS
//  DATA_W       8   bits per word (>=2)
//  SYNC_STAGES  2   synchroniser depth on sclk/mosi/ss_n (>=2)
// PORTS
//  clk             in   1       system clock; all logic on posedge
//  rst             in   1       synchronous, active-high reset
//  sclk            in   1       SPI clock from master (async to clk)
//  mosi            in   1       master-out data
//  ss_n            in   1       slave select, active low
//  miso            out  1       slave-out data; 0 when not selected
//  slave_data_in   in   DATA_W  next word to transmit; captured on tx_load
//  slave_data_out  out  DATA_W  last completely received word
//  rx_valid        out  1       1-cycle pulse: slave_data_out updated
//  tx_load         out  1       1-cycle pulse: slave_data_in captured into tx shifter
//  frame_active    out  1       high while in ACTIVE state
//  frame_abort     out  1       1-cycle pulse: ss_n rose with partial word
// BEHAVIOUR
//  Reset (rst=1 at posedge): miso=0, slave_data_out=0, rx_valid=tx_load=frame_abort=0, frame_active=0,
//   bit_cnt=0, shifters=0, sync flops=0, state=WAIT_DESEL. Reset mid-frame discards the partial word.
//  Sync: sclk_s/mosi_s/ss_n_s = SYNC_STAGES-deep sync outputs; one more flop gives sclk_rise/sclk_fall/
//   ss_fall/ss_rise as comb. compares (edge seen SYNC_STAGES+1 clks after pin edge).
//  Timing constraint on master: SCLK high and low phases each >= SYNC_STAGES+2 clk periods.
//  FSM (priority in listed order within a state):
//   WAIT_DESEL: -> IDLE when ss_n_s==1. Blocks frames already in progress when reset released.
//   IDLE: ss_fall -> ACTIVE; tx_sh<=slave_data_in, tx_load=1, bit_cnt=0. SCLK edges ignored.
//   ACTIVE: ss_rise -> IDLE; frame_abort=1 iff bit_cnt!=0; bit_cnt<=0; no rx_valid for partial word.
//    sclk_rise: rx_sh<={rx_sh[DATA_W-2:0],mosi_s}; bit_cnt++. If bit_cnt==DATA_W-1: slave_data_out<=
//     {rx_sh[DATA_W-2:0],mosi_s}, rx_valid=1 next cycle, bit_cnt<=0, set word_done.
//    sclk_fall: if word_done: tx_sh<=slave_data_in, tx_load=1, clear word_done; else tx_sh<<=1.
//  miso = tx_sh[DATA_W-1] when state==ACTIVE, else 0 (registered, no tristate here).
//  First MISO bit valid SYNC_STAGES+2 clks after ss_n falls; master first SCLK rise must follow.
//  ss_fall and sclk edge in same cycle: ss_fall wins, SCLK edge dropped. ss_rise beats sclk edges likewise.
//  Word complete and ss_rise in later cycle: rx_valid fires, frame_abort does not (bit_cnt==0).
//  No overrun flag: consumer must take slave_data_out within DATA_W SCLK periods; it simply updates.
//  rx_valid latency: asserted SYNC_STAGES+2 clks after the final SCLK rising edge at the pin.
// STRUCTURE
//  spi_pkg: typedef enum logic [1:0] {WAIT_DESEL, IDLE, ACTIVE} spi_slv_state_t; SPI_DATA_W=8.
//  Sub-module spi_sync_edge: SYNC_STAGES-deep sync + edge-detect flop, outputs level/rise/fall;
//   instantiated for sclk, ss_n; mosi uses same module, level output only.
//  Top: FSM, bit counter ($clog2(DATA_W) bits), rx/tx shifters, output regs. Est. 150-250 lines.
// TESTING (mode-0 master BFM, SCLK half-period 6 clks, SYNC_STAGES=2)
//  1 Single word: slave_data_in=8'hA5, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; one tx_load at
//    frame start; one rx_valid; slave_data_out=8'h3C; frame_active high only while ss_n low.
//  2 Back-to-back in one frame: master 8'h12,8'h34; slave_data_in->8'h5A after first tx_load ->
//    two rx_valid (8'h12 then 8'h34), miso second word 8'h5A, tx_load pulses = 3 (start + 2 boundaries).
//  3 Abort: ss_n rises after 5 SCLK cycles -> frame_abort 1 pulse, no rx_valid, slave_data_out
//    unchanged; next full frame 8'hC3 received correctly.
//  4 Reset mid-word (bit 4), ss_n held low -> all outputs 0 next cycle; further SCLK ignored until
//    ss_n goes high; following frame 8'h81 received correctly.
//  5 SCLK toggles 16 times with ss_n high -> no rx_valid/tx_load, miso=0, slave_data_out unchanged.
//  6 ss_n fall coincident (same clk) with sclk rise at sync output -> edge dropped; word realigns
//    on next rise; check no spurious rx_valid; random-data loop 200 words, scoreboard both directions.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_pkg;
    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        WAIT_DESEL,
        IDLE,
        ACTIVE
    } spi_slv_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one async pin plus a history flop for edge detect.
// Level appears SYNC_STAGES clks after the pin; rise/fall are combinational compares.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;
endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 responder, MSB first, oversampling SCLK/MOSI/SS_N in the clk domain.
// Multi-word frames: a new tx word is loaded on the SCLK fall that follows each completed word.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    input  logic [DATA_W-1:0] slave_data_in,
    output logic [DATA_W-1:0] slave_data_out,
    output logic              rx_valid,
    output logic              tx_load,
    output logic              frame_active,
    output logic              frame_abort
);
    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic w_ss_s, w_ss_rise, w_ss_fall;
    logic w_unused_sync;
    logic [DATA_W-1:0] w_rx_next;

    spi_slv_state_t    r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-2:0] r_rx_sh;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_data_out;
    logic              r_word_done;
    logic              r_rx_pend;
    logic              r_rx_valid;
    logic              r_tx_load;
    logic              r_abort;
    logic              r_miso;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_async(mosi),
        .o_level(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .i_async(ss_n),
        .o_level(w_ss_s), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    assign w_unused_sync = &{1'b0, w_sclk_lvl, w_mosi_rise, w_mosi_fall};
    assign w_rx_next     = {r_rx_sh, w_mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT_DESEL;
            r_bit_cnt   <= '0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_data_out  <= '0;
            r_word_done <= 1'b0;
            r_rx_pend   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_load   <= 1'b0;
            r_abort     <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_tx_load  <= 1'b0;
            r_abort    <= 1'b0;
            r_rx_pend  <= 1'b0;
            r_rx_valid <= r_rx_pend;
            r_miso     <= (r_state == ACTIVE) ? r_tx_sh[DATA_W-1] : 1'b0;
            case (r_state)
                // Stay here after reset until the master releases select, so a
                // frame already in flight is never picked up half-way.
                WAIT_DESEL: begin
                    if (w_ss_s) r_state <= IDLE;
                end
                IDLE: begin
                    if (w_ss_fall) begin
                        r_state     <= ACTIVE;
                        r_tx_sh     <= slave_data_in;
                        r_tx_load   <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (w_ss_rise) begin
                        r_state     <= IDLE;
                        r_abort     <= (r_bit_cnt != '0);
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_rx_sh <= w_rx_next[DATA_W-2:0];
                        if (r_bit_cnt == LAST_BIT) begin
                            r_data_out  <= w_rx_next;
                            r_rx_pend   <= 1'b1;
                            r_bit_cnt   <= '0;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else if (w_sclk_fall) begin
                        if (r_word_done) begin
                            r_tx_sh     <= slave_data_in;
                            r_tx_load   <= 1'b1;
                            r_word_done <= 1'b0;
                        end else begin
                            r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: r_state <= WAIT_DESEL;
            endcase
        end
    end

    assign miso           = r_miso;
    assign slave_data_out = r_data_out;
    assign rx_valid       = r_rx_valid;
    assign tx_load        = r_tx_load;
    assign frame_active   = (r_state == ACTIVE);
    assign frame_abort    = r_abort;
endmodule
